// File: rtl/flash_pkg.sv
// Shared flash-strobe definitions: state encoding and default timing used by the
// pulse stretcher and the flash debouncer.
package flash_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ASSERT = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;

   // 2'd3 is never entered; it is named so the recovery path is explicit
   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_ASSERT = ST_ASSERT,
      S_GAP    = ST_GAP,
      S_BAD    = 2'd3
   } state_t;

   localparam int DEF_HOLD_TIME = 3;
   localparam int DEF_GAP_TIME  = 3;

endpackage

// File: rtl/pulse_stretch_for_flash_if.sv
// Request/strobe bundle between the flash control logic and the pulse stretcher.
interface pulse_stretch_for_flash_if #(
   parameter int PEND_W = 4
);
   logic              trig_in;
   logic              pulse_n;
   logic              busy;
   logic              drop;
   logic [PEND_W-1:0] pend_cnt;

   modport master (output trig_in, input pulse_n, busy, drop, pend_cnt);
   modport slave  (input trig_in, output pulse_n, busy, drop, pend_cnt);
endinterface

// File: rtl/pulse_stretch_for_flash.sv
// Stretches 1-cycle requests into active-low pulses of fixed width with a guaranteed gap.
// Define PULSE_QUEUE_EN to queue requests that arrive mid-pulse instead of dropping them.
module pulse_stretch_for_flash
   import flash_pkg::*;
#(
   parameter int HOLD_TIME = DEF_HOLD_TIME,
   parameter int GAP_TIME  = DEF_GAP_TIME,
   parameter int CNT_W     = 15,
   parameter int PEND_W    = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   pulse_stretch_for_flash_if.slave  bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIME - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TIME - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pulse_n_q, busy_q, drop_q, drop_d;
   logic               gap_term, in_flight, pend_any;

   assign gap_term  = (state_q == S_GAP) && (cnt_q == GAP_LAST);
   // the terminal gap cycle consumes trig_in directly, so it is not "in flight"
   assign in_flight = (state_q == S_ASSERT) || ((state_q == S_GAP) && !gap_term);

`ifdef PULSE_QUEUE_EN
   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   logic [PEND_W-1:0] pend_q, pend_d;

   assign pend_any = (pend_q != '0);

   always_comb begin
      pend_d = pend_q;
      drop_d = 1'b0;
      if (bus.trig_in && in_flight) begin
         if (pend_q == PEND_MAX) drop_d = 1'b1;
         else                    pend_d = pend_q + PEND_W'(1);
      end else if (gap_term && pend_any && !bus.trig_in) begin
         pend_d = pend_q - PEND_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) pend_q <= '0;
      else          pend_q <= pend_d;
   end

   assign bus.pend_cnt = pend_q;
`else
   assign pend_any     = 1'b0;
   assign drop_d       = bus.trig_in && in_flight;
   assign bus.pend_cnt = '0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.trig_in) begin
               state_d = S_ASSERT;
               cnt_d   = '0;
            end
         end
         S_ASSERT: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (gap_term) begin
               state_d = (pend_any || bus.trig_in) ? S_ASSERT : S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // outputs are derived from the next state so they change on the same edge as the FSM
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pulse_n_q <= 1'b1;
         busy_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pulse_n_q <= (state_d != S_ASSERT);
         busy_q    <= (state_d == S_ASSERT) || (state_d == S_GAP);
         drop_q    <= drop_d;
      end
   end

   assign bus.pulse_n = pulse_n_q;
   assign bus.busy    = busy_q;
   assign bus.drop    = drop_q;

endmodule

// File: tb/tb_pulse_stretch_for_flash.sv
// Bench for pulse_stretch_for_flash: directed scenarios plus random traffic against a
// pulse-timeline model. Follows PULSE_QUEUE_EN the same way the design does.
module tb_pulse_stretch_for_flash;

   localparam int H    = 3;
   localparam int G    = 3;
   localparam int CW   = 15;
   localparam int PW   = 4;
   localparam int PMAX = (1 << PW) - 1;
`ifdef PULSE_QUEUE_EN
   localparam bit QEN = 1'b1;
`else
   localparam bit QEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   pulse_stretch_for_flash_if #(.PEND_W(PW)) bus ();

   pulse_stretch_for_flash #(
      .HOLD_TIME(H), .GAP_TIME(G), .CNT_W(CW), .PEND_W(PW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model: a pulse occupies H+G cycles; m_t is the position inside it
   bit m_act  = 1'b0;
   int m_t    = 0;
   int m_pend = 0;
   bit m_drop = 1'b0;

   int cyc      = 0;
   bit prev_pn  = 1'b1;
   int st_q[$];
   int ndrop    = 0;
   int pend_pk  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
      end
   endtask

   task automatic model(input bit trig, input bit rn);
      m_drop = 1'b0;
      if (!rn) begin
         m_act = 1'b0; m_t = 0; m_pend = 0;
      end else if (!m_act) begin
         if (trig) begin m_act = 1'b1; m_t = 0; end
      end else if (m_t == H + G - 1) begin
         if (m_pend + int'(trig) > 0) begin
            m_pend = m_pend + int'(trig) - 1;
            m_t    = 0;
         end else begin
            m_act = 1'b0;
         end
      end else begin
         m_t++;
         if (trig) begin
            if (QEN && m_pend < PMAX) m_pend++;
            else                      m_drop = 1'b1;
         end
      end
   endtask

   task automatic step(input bit trig, input bit rn);
      bus.trig_in = trig;
      reset_n     = rn;
      @(posedge clk);
      model(trig, rn);
      cyc++;
      #1;
      if (prev_pn === 1'b1 && bus.pulse_n === 1'b0) st_q.push_back(cyc);
      prev_pn = bus.pulse_n;
      if (bus.drop === 1'b1) ndrop++;
      if (int'(bus.pend_cnt) > pend_pk) pend_pk = int'(bus.pend_cnt);
      chk("pulse_n",  32'(bus.pulse_n),  32'(!(m_act && m_t < H)));
      chk("busy",     32'(bus.busy),     32'(m_act));
      chk("drop",     32'(bus.drop),     32'(m_drop));
      chk("pend_cnt", 32'(bus.pend_cnt), 32'(m_pend));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1);
   endtask

   int t0;

   initial begin
      bus.trig_in = 1'b0;

      // reset held with trig asserted
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0);
         chk("rst_pulse_n", 32'(bus.pulse_n), 32'd1);
         chk("rst_busy",    32'(bus.busy),    32'd0);
         chk("rst_pend",    32'(bus.pend_cnt), 32'd0);
      end
      idle(3);

      // single request: low 1..3, high 4..6, idle from 7
      step(1'b1, 1'b1);
      for (int c = 1; c <= 7; c++) begin
         chk("single_pulse_n", 32'(bus.pulse_n), 32'(c >= 4));
         chk("single_busy",    32'(bus.busy),    32'(c <= 6));
         step(1'b0, 1'b1);
      end
      idle(3);

      // three back-to-back requests
      st_q.delete();
      t0 = cyc;
      step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
`ifdef PULSE_QUEUE_EN
      chk("b2b_pend", 32'(bus.pend_cnt), 32'd2);
`else
      chk("b2b_drop", 32'(bus.drop), 32'd1);
`endif
      idle(25);
`ifdef PULSE_QUEUE_EN
      chk("b2b_npulse", 32'(st_q.size()), 32'd3);
      if (st_q.size() == 3) begin
         chk("b2b_start0", 32'(st_q[0] - t0), 32'd1);
         chk("b2b_start1", 32'(st_q[1] - t0), 32'd7);
         chk("b2b_start2", 32'(st_q[2] - t0), 32'd13);
      end
`else
      chk("b2b_npulse", 32'(st_q.size()), 32'd1);
`endif
      chk("b2b_pend_end", 32'(bus.pend_cnt), 32'd0);

      // 21 consecutive requests: saturation / drop behaviour
      st_q.delete();
      ndrop   = 0;
      pend_pk = 0;
      for (int i = 0; i < 21; i++) step(1'b1, 1'b1);
      idle(130);
`ifdef PULSE_QUEUE_EN
      chk("sat_pend_peak", 32'(pend_pk),     32'(PMAX));
      chk("sat_drops",     32'(ndrop),       32'd2);
      chk("sat_npulse",    32'(st_q.size()), 32'd19);
`else
      chk("sat_pend_peak", 32'(pend_pk),     32'd0);
      chk("sat_drops",     32'(ndrop),       32'd17);
      chk("sat_npulse",    32'(st_q.size()), 32'd4);
`endif

      // trig at cycles 0 and 2
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
`ifdef PULSE_QUEUE_EN
      chk("two_pend", 32'(bus.pend_cnt), 32'd1);
      chk("two_drop", 32'(bus.drop),     32'd0);
`else
      chk("two_pend", 32'(bus.pend_cnt), 32'd0);
      chk("two_drop", 32'(bus.drop),     32'd1);
`endif
      idle(20);

      // trig in the gap terminal cycle, then reset mid-pulse
      step(1'b1, 1'b1);
      idle(5);
      step(1'b1, 1'b1);
      chk("term_pulse_n", 32'(bus.pulse_n), 32'd0);
      chk("term_busy",    32'(bus.busy),    32'd1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk("midrst_pulse_n", 32'(bus.pulse_n), 32'd1);
      chk("midrst_busy",    32'(bus.busy),    32'd0);
      idle(4);

      // random traffic with occasional resets
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) >= 3));
      idle(120);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
